// File: rtl/io_control_sequencer_if.sv
// Control/status bundle between the I/O-class sequencer and the CPUproject datapath.
// master = sequencer (drives strobes), slave = datapath (supplies opcode and handshakes).
interface io_control_sequencer_if;
    logic [4:0] operation;
    logic       mem_ready;
    logic       out_busy;

    logic       PCout;
    logic       MARin;
    logic       IncPC;
    logic       ZLowIn;
    logic       ZLowout;
    logic       PCin;
    logic       Read;
    logic       MDRin;
    logic       MDRout;
    logic       IRin;
    logic       GRA;
    logic       R_in;
    logic       R_out;
    logic       InPortout;
    logic       HIout;
    logic       LOout;
    logic       enableOutputPort;

    logic       run;
    logic       illegal;
    logic [3:0] state_dbg;

    modport master (
        input  operation, mem_ready, out_busy,
        output PCout, MARin, IncPC, ZLowIn, ZLowout, PCin, Read, MDRin, MDRout, IRin,
               GRA, R_in, R_out, InPortout, HIout, LOout, enableOutputPort,
               run, illegal, state_dbg
    );

    modport slave (
        output operation, mem_ready, out_busy,
        input  PCout, MARin, IncPC, ZLowIn, ZLowout, PCin, Read, MDRin, MDRout, IRin,
               GRA, R_in, R_out, InPortout, HIout, LOout, enableOutputPort,
               run, illegal, state_dbg
    );
endinterface

// File: rtl/io_control_sequencer.sv
// Hardwired Moore sequencer: fetch (T0-T2), decode and single-cycle execute (T3) for
// out/in/mfhi/mflo/nop/halt, with stalls on memory read and output-port back-pressure.
module io_control_sequencer #(
    parameter logic [4:0] OP_IN   = 5'b10101,
    parameter logic [4:0] OP_OUT  = 5'b10110,
    parameter logic [4:0] OP_MFHI = 5'b11000,
    parameter logic [4:0] OP_MFLO = 5'b11001,
    parameter logic [4:0] OP_NOP  = 5'b11010,
    parameter logic [4:0] OP_HALT = 5'b11011
) (
    input  logic                          clk,
    input  logic                          clr,
    io_control_sequencer_if.master        ctl
);

    typedef enum logic [3:0] {
        StRst  = 4'd0,
        StT0   = 4'd7,
        StT1   = 4'd8,
        StT2   = 4'd9,
        StT3   = 4'd10,
        StHalt = 4'd15
    } state_e;

    state_e state_q, state_d;
    logic   t1_stall_q, t1_stall_d;
    logic   illegal_q, illegal_d;
    logic   op_known;

    always_comb begin
        unique case (ctl.operation)
            OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_NOP, OP_HALT: op_known = 1'b1;
            default:                                          op_known = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= StRst;
            t1_stall_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            t1_stall_q <= t1_stall_d;
            illegal_q  <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRst:  state_d = StT0;
            StT0:   state_d = StT1;
            StT1:   if (ctl.mem_ready) state_d = StT2;
            StT2:   state_d = StT3;
            StT3: begin
                if (ctl.operation == OP_OUT) begin
                    if (!ctl.out_busy) state_d = StT0;
                end else if (ctl.operation == OP_HALT) begin
                    state_d = StHalt;
                end else begin
                    state_d = StT0;
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StRst;
        endcase
        // Remember that PC was already loaded so stall cycles in T1 drop PCin.
        t1_stall_d = (state_q == StT1) && (state_d == StT1);
        illegal_d  = (state_q == StT3) && !op_known;
    end

    always_comb begin
        ctl.PCout            = 1'b0;
        ctl.MARin            = 1'b0;
        ctl.IncPC            = 1'b0;
        ctl.ZLowIn           = 1'b0;
        ctl.ZLowout          = 1'b0;
        ctl.PCin             = 1'b0;
        ctl.Read             = 1'b0;
        ctl.MDRin            = 1'b0;
        ctl.MDRout           = 1'b0;
        ctl.IRin             = 1'b0;
        ctl.GRA              = 1'b0;
        ctl.R_in             = 1'b0;
        ctl.R_out            = 1'b0;
        ctl.InPortout        = 1'b0;
        ctl.HIout            = 1'b0;
        ctl.LOout            = 1'b0;
        ctl.enableOutputPort = 1'b0;
        ctl.run              = (state_q != StHalt);
        ctl.illegal          = illegal_q;
        ctl.state_dbg        = state_q;
        case (state_q)
            StT0: begin
                ctl.PCout  = 1'b1;
                ctl.MARin  = 1'b1;
                ctl.IncPC  = 1'b1;
                ctl.ZLowIn = 1'b1;
            end
            StT1: begin
                ctl.ZLowout = 1'b1;
                ctl.PCin    = !t1_stall_q;
                ctl.Read    = 1'b1;
                ctl.MDRin   = 1'b1;
            end
            StT2: begin
                ctl.MDRout = 1'b1;
                ctl.IRin   = 1'b1;
            end
            StT3: begin
                // nop, halt and undefined opcodes assert nothing here.
                if (ctl.operation == OP_OUT) begin
                    ctl.GRA              = 1'b1;
                    ctl.R_out            = 1'b1;
                    ctl.enableOutputPort = 1'b1;
                end else if (ctl.operation == OP_IN) begin
                    ctl.InPortout = 1'b1;
                    ctl.GRA       = 1'b1;
                    ctl.R_in      = 1'b1;
                end else if (ctl.operation == OP_MFHI) begin
                    ctl.HIout = 1'b1;
                    ctl.GRA   = 1'b1;
                    ctl.R_in  = 1'b1;
                end else if (ctl.operation == OP_MFLO) begin
                    ctl.LOout = 1'b1;
                    ctl.GRA   = 1'b1;
                    ctl.R_in  = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_io_control_sequencer.sv
// Scoreboard bench: stimulus pushes the expected post-edge state; a monitor pops and compares.
module tb_io_control_sequencer;

    localparam logic [3:0] S_RST  = 4'd0;
    localparam logic [3:0] S_T0   = 4'd7;
    localparam logic [3:0] S_T1   = 4'd8;
    localparam logic [3:0] S_T2   = 4'd9;
    localparam logic [3:0] S_T3   = 4'd10;
    localparam logic [3:0] S_HALT = 4'd15;

    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam logic [4:0] OP_BAD  = 5'b00111;

    typedef struct packed {
        logic [3:0] st;
        logic       first;
        logic [4:0] op;
        logic       ill;
        logic       run;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    io_control_sequencer_if bus ();

    io_control_sequencer dut (
        .clk (clk),
        .clr (clr),
        .ctl (bus)
    );

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [16:0] act;
    logic [6:0]  drv;
    assign act = {bus.PCout, bus.MARin, bus.IncPC, bus.ZLowIn, bus.ZLowout, bus.PCin, bus.Read,
                  bus.MDRin, bus.MDRout, bus.IRin, bus.GRA, bus.R_in, bus.R_out, bus.InPortout,
                  bus.HIout, bus.LOout, bus.enableOutputPort};
    assign drv = {bus.PCout, bus.ZLowout, bus.MDRout, bus.R_out, bus.InPortout, bus.HIout,
                  bus.LOout};

    function automatic logic [16:0] exp_strb(input exp_t e);
        logic [16:0] v;
        v = '0;
        case (e.st)
            S_T0: v[16:13] = 4'b1111;
            S_T1: begin
                v[12] = 1'b1;
                v[11] = e.first;
                v[10] = 1'b1;
                v[9]  = 1'b1;
            end
            S_T2: v[8:7] = 2'b11;
            S_T3: begin
                case (e.op)
                    OP_OUT:  begin v[6] = 1'b1; v[4] = 1'b1; v[0] = 1'b1; end
                    OP_IN:   begin v[6] = 1'b1; v[5] = 1'b1; v[3] = 1'b1; end
                    OP_MFHI: begin v[6] = 1'b1; v[5] = 1'b1; v[2] = 1'b1; end
                    OP_MFLO: begin v[6] = 1'b1; v[5] = 1'b1; v[1] = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: compares every cycle that has a queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            check("bus_exclusive", 32'($countones(drv) <= 1), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("state", 32'(bus.state_dbg), 32'(e.st));
                check("strobes", 32'(act), 32'(exp_strb(e)));
                check("run", 32'(bus.run), 32'(e.run));
                check("illegal", 32'(bus.illegal), 32'(e.ill));
            end
        end
    end

    task automatic step(input logic [3:0] st, input logic first, input logic ill,
                        input logic run_e);
        exp_t e;
        e.st    = st;
        e.first = first;
        e.op    = bus.operation;
        e.ill   = ill;
        e.run   = run_e;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts in T0 (at a falling edge); ends in T0 or HALT.
    task automatic instr(input logic [4:0] op, input int mstall, input int ostall,
                         input logic ob_t3, input logic ill_exp);
        bus.operation = op;
        bus.out_busy  = 1'b0;
        bus.mem_ready = 1'b0;
        step(S_T1, 1'b1, 1'b0, 1'b1);
        repeat (mstall) step(S_T1, 1'b0, 1'b0, 1'b1);
        bus.mem_ready = 1'b1;
        step(S_T2, 1'b0, 1'b0, 1'b1);
        bus.mem_ready = 1'b0;
        step(S_T3, 1'b0, 1'b0, 1'b1);
        repeat (ostall) begin
            bus.out_busy = 1'b1;
            step(S_T3, 1'b0, 1'b0, 1'b1);
        end
        bus.out_busy = ob_t3;
        if (op == OP_HALT) step(S_HALT, 1'b0, 1'b0, 1'b0);
        else               step(S_T0, 1'b0, ill_exp, 1'b1);
        bus.out_busy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.operation = OP_NOP;
        bus.mem_ready = 1'b0;
        bus.out_busy  = 1'b0;
        #1 clr = 1'b0;
        @(negedge clk);
        step(S_RST, 1'b0, 1'b0, 1'b1);
        step(S_RST, 1'b0, 1'b0, 1'b1);
        clr = 1'b1;
        step(S_T0, 1'b0, 1'b0, 1'b1);

        instr(OP_OUT,  0, 0, 1'b0, 1'b0);
        instr(OP_OUT,  3, 0, 1'b0, 1'b0);
        instr(OP_OUT,  0, 2, 1'b0, 1'b0);
        instr(OP_IN,   0, 0, 1'b1, 1'b0);
        instr(OP_MFHI, 1, 0, 1'b0, 1'b0);
        instr(OP_MFLO, 0, 0, 1'b1, 1'b0);
        instr(OP_NOP,  0, 0, 1'b0, 1'b0);
        instr(OP_BAD,  0, 0, 1'b0, 1'b1);
        instr(OP_NOP,  0, 0, 1'b0, 1'b0);
        instr(OP_HALT, 0, 0, 1'b0, 1'b0);
        bus.mem_ready = 1'b1;
        repeat (10) step(S_HALT, 1'b0, 1'b0, 1'b0);
        bus.mem_ready = 1'b0;

        clr = 1'b0;
        step(S_RST, 1'b0, 1'b0, 1'b1);
        clr = 1'b1;
        step(S_T0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a T1 stall cycle.
        bus.operation = OP_NOP;
        bus.mem_ready = 1'b0;
        step(S_T1, 1'b1, 1'b0, 1'b1);
        step(S_T1, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #3 clr = 1'b0;
        #1;
        check("async_state", 32'(bus.state_dbg), 32'(S_RST));
        check("async_strobes", 32'(act), 32'd0);
        check("async_illegal", 32'(bus.illegal), 32'd0);
        @(negedge clk);
        step(S_RST, 1'b0, 1'b0, 1'b1);
        clr = 1'b1;
        step(S_T0, 1'b0, 1'b0, 1'b1);
        instr(OP_MFLO, 0, 0, 1'b0, 1'b0);

        @(posedge clk);
        #3;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_control_sequencer.md
Name: io_control_sequencer

Overview:
- Hardwired Moore control unit that drives the CPUproject datapath control inputs.
- Runs instruction fetch (T0–T2), decode, and single-cycle execute (T3) for the I/O and special-register class: out, in, mfhi, mflo, nop, halt.
- Replaces hand-sequenced control. It sits directly upstream of the datapath, reads the opcode back from the datapath, and stalls on memory and output-port handshakes.

Parameters:
- OP_IN, 5'b10101, opcode for in Ra (InPort → R[Ra])
- OP_OUT, 5'b10110, opcode for out Ra (R[Ra] → OutPort)
- OP_MFHI, 5'b11000, opcode for mfhi Ra (HI → R[Ra])
- OP_MFLO, 5'b11001, opcode for mflo Ra (LO → R[Ra])
- OP_NOP, 5'b11010, opcode for nop
- OP_HALT, 5'b11011, opcode for halt

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous active-low reset
- operation  in  5  IR[31:27] from datapath
- mem_ready  in  1  RAM read data valid on MDatain
- out_busy  in  1  downstream output-port consumer not ready
- PCout, MARin, IncPC, ZLowIn, ZLowout, PCin  out  1  datapath strobes
- Read, MDRin, MDRout, IRin  out  1  datapath strobes
- GRA, R_in, R_out  out  1  register-file select and strobes
- InPortout, HIout, LOout, enableOutputPort  out  1  datapath strobes
- run  out  1  1 while executing; 0 in HALT
- illegal  out  1  one-cycle pulse on undefined opcode
- state_dbg  out  4  current state encoding

Behaviour:
- State register is reset asynchronously when clr=0. Reset state is RST: every strobe is 0, illegal=0, run=1.
- Transition from RST to T0 is taken on the first rising edge with clr=1.
- Outputs are a pure function of the registered state (Moore). Exception: illegal is registered and is high for exactly the cycle after decode.
- Encodings: RST=0, T0=7, T1=8, T2=9, T3=10, HALT=15.
- T0: PCout, MARin, IncPC, ZLowIn. Z ← PC+1. Always goes to T1.
- T1: ZLowout, PCin, Read, MDRin.
  - PC is updated on the first T1 cycle only; PCin is deasserted on any stall cycle after that.
  - mem_ready=0: stay in T1 with Read and MDRin held.
  - mem_ready=1: go to T2.
- T2: MDRout, IRin. Always goes to T3. operation is valid from T3 onward.
- T3, decoded from operation:
  - OP_OUT: GRA, R_out, enableOutputPort. If out_busy=1, hold T3 with all three held. Otherwise go to T0.
  - OP_IN: InPortout, GRA, R_in. Go to T0.
  - OP_MFHI: HIout, GRA, R_in. Go to T0.
  - OP_MFLO: LOout, GRA, R_in. Go to T0.
  - OP_NOP: no strobes. Go to T0.
  - OP_HALT: no strobes. Go to HALT.
  - Any other opcode: treat as nop, set illegal for one cycle, go to T0.
- HALT: all strobes 0, run=0. Remains in HALT until clr is asserted.
- Bus exclusivity: at most one bus driver is asserted in any state. Drivers are PCout, ZLowout, MDRout, R_out, InPortout, HIout, LOout.
- Reset mid-operation (any state, including stalls): outputs go to 0 immediately (asynchronous), and illegal clears.
- Simultaneous events: mem_ready and out_busy are sampled only in their own states. out_busy is ignored for non-out opcodes.
- Cycle count with no stalls: 4 clocks per instruction (T0–T3).
- Stall counts:
  - Each cycle of mem_ready=0 in T1 adds one clock.
  - Each cycle of out_busy=1 in an out instruction's T3 adds one clock.

Test Plan:
- Reset then fetch: hold clr=0 for 2 cycles, release, mem_ready=1, operation=5'b10110 (IR 0xB0800000), out_busy=0 → states go RST,T0,T1,T2,T3,T0. In T3, GRA=R_out=enableOutputPort=1. run=1 throughout.
- Memory stall: mem_ready=0 for 3 cycles in T1 → T1 lasts 4 cycles. Read and MDRin are high throughout. PCin is high only in the first T1 cycle. T2 follows the cycle mem_ready=1.
- Output back-pressure: out instruction with out_busy=1 for 2 cycles → T3 lasts 3 cycles with strobes held, then T0.
- in, mfhi, mflo sequence → T3 asserts InPortout, HIout, LOout respectively, each with GRA=R_in=1. Check exactly one bus driver high in every cycle.
- Illegal opcode 5'b00111 → illegal=1 for exactly one cycle and returns to T0. halt (5'b11011) → HALT with run=0 and all strobes 0 for 10+ cycles.
- Reset mid-operation: assert clr=0 asynchronously mid-cycle during T1 stall → all outputs 0 before the next edge. After release, restarts at T0 one edge later.
